// File: rtl/fifo_axis_burst_reader_pkg.sv
// Shared types for the FIFO read-side burst reader: FSM states and the
// {data, last} entry held in the output skid buffer.
package fifo_axis_burst_reader_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
  } beat_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_axis_burst_reader_skid.sv
// Two-entry valid/ready skid buffer; push is owned by the caller, which must
// never push while occ==2 unless the same cycle also drains a beat.
module axis_skid_buf2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pop    = (occ_q != 2'd0) && out_ready;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy holds; at occ=1 the new word replaces the departing head.
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_axis_burst_reader.sv
// Drains an FWFT FIFO read port into tlast-framed bursts on a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for enough words (or a flush) to start a burst
//   BURST | popping words into the skid buffer until len beats are taken
module fifo_axis_burst_reader
  import fifo_axis_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int CNT_WIDTH  = 4,
  parameter int BURST_LEN  = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic                  fifo_empty,
  input  logic [CNT_WIDTH-1:0]  rd_data_count,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  burst_done,
  output logic [LEN_WIDTH-1:0]  burst_len_o
);

  localparam int CMP_W = max_int(CNT_WIDTH, LEN_WIDTH);

  rd_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d;
  logic [CMP_W-1:0]     count_ext;
  logic [CMP_W-1:0]     full_len;
  logic [1:0]           occ;
  beat_t                push_beat;
  beat_t                head_beat;
  logic [$bits(beat_t)-1:0] head_bits;

  assign count_ext = CMP_W'(rd_data_count);
  assign full_len  = CMP_W'(BURST_LEN);

  // Registered occupancy only, so m_tready never reaches rd_en combinationally.
  assign rd_en = (state_q == BURST) && !fifo_empty && (occ != 2'd2);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    push_beat.data = rd_data;
    push_beat.last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (count_ext >= full_len) begin
            len_d   = LEN_WIDTH'(BURST_LEN);
            cnt_d   = '0;
            state_d = BURST;
          end else if (flush_req && (count_ext != '0)) begin
            // Below BURST_LEN here, so the count itself is the min().
            len_d   = LEN_WIDTH'(count_ext);
            cnt_d   = '0;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (rd_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            push_beat.last = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = m_tvalid && m_tready && m_tlast;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  axis_skid_buf2 #(
    .W($bits(beat_t))
  ) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (rd_en),
    .push_data (push_beat),
    .out_ready (m_tready),
    .out_valid (m_tvalid),
    .out_data  (head_bits),
    .occ       (occ)
  );

  assign head_beat   = head_bits;
  assign m_tdata     = head_beat.data;
  assign m_tlast     = head_beat.last;
  assign busy        = (state_q == BURST) || (occ != 2'd0);
  assign burst_done  = done_q;
  assign burst_len_o = len_q;

endmodule

// File: tb/tb_fifo_axis_burst_reader.sv
// Randomized bench for fifo_axis_burst_reader against a queue-based model of
// the FIFO, burst framing and output stream.
module tb_fifo_axis_burst_reader;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int BL = 4;
  localparam int LW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush_req = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [CW-1:0] rd_data_count = '0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          busy;
  logic          burst_done;
  logic [LW-1:0] burst_len_o;

  fifo_axis_burst_reader #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL), .LEN_WIDTH(LW)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable), .flush_req(flush_req),
    .fifo_empty(fifo_empty), .rd_data_count(rd_data_count), .rd_data(rd_data),
    .rd_en(rd_en), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .busy(busy), .burst_done(burst_done), .burst_len_o(burst_len_o)
  );

  always #5 rd_clk = ~rd_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fq[$];
  logic [DW:0]   sb[$];
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  logic [DW-1:0] exp_words[$];

  logic          pend_pop = 1'b0;
  logic          force_empty = 1'b0;
  logic          rand_empty = 1'b0;
  int            ready_mode = 0;
  int            occ_m = 0;
  int            bpos_m = 0;
  int            blen_m = 0;
  int            bd_cnt = 0;
  logic          prev_stall = 1'b0;
  logic          prev_last_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          hs;
  logic [DW:0]   e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    rd_data       = (fq.size() != 0) ? fq[0] : '0;
    fifo_empty    = (fq.size() == 0) || force_empty;
    rd_data_count = (fq.size() > 15) ? 4'd15 : CW'(fq.size());
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
    if (pend_pop && fq.size() != 0) void'(fq.pop_front());
    pend_pop = 1'b0;
    if (rand_empty) force_empty = ($urandom_range(0, 3) == 0);
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    drive_fifo();
  endtask

  task automatic preload(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
    drive_fifo();
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    bd_cnt = 0;
  endtask

  function automatic int n_lasts();
    int n = 0;
    foreach (got_last[i]) if (got_last[i]) n++;
    return n;
  endfunction

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 800 && quiet < 4; i++) begin
      step();
      quiet = busy ? 0 : quiet + 1;
    end
    chk("drain_timeout", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic wait_bpos(input int target);
    int hit = 0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      step();
      if (bpos_m >= target) hit = 1;
    end
    chk("wait_beat_timeout", 32'(hit), 32'd1);
  endtask

  // Compare process: checks every cycle against the queue model.
  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_burst_done", 32'(burst_done), 32'd0);
      chk("rst_burst_len", 32'(burst_len_o), 32'd0);
      occ_m = 0; bpos_m = 0; sb.delete(); pend_pop = 1'b0;
      prev_stall = 1'b0; prev_last_hs = 1'b0;
    end else begin
      hs = m_tvalid && m_tready;
      chk("tvalid_vs_occ", 32'(m_tvalid), 32'(occ_m != 0));
      chk("burst_done", 32'(burst_done), 32'(prev_last_hs));
      if (burst_done) bd_cnt++;
      if (m_tvalid) chk("busy_with_data", 32'(busy), 32'd1);
      if (prev_stall) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", m_tdata, prev_data);
        chk("hold_last", 32'(m_tlast), 32'(prev_last));
      end
      if (hs) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", m_tdata, 32'hdead_beef);
        end else begin
          e = sb.pop_front();
          chk("tdata", m_tdata, e[DW:1]);
          chk("tlast", 32'(m_tlast), 32'(e[0]));
        end
        got_data.push_back(m_tdata);
        got_last.push_back(m_tlast);
      end
      if (rd_en) begin
        chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        chk("rd_en_at_occ2", 32'(occ_m == 2), 32'd0);
        chk("busy_in_burst", 32'(busy), 32'd1);
        if (bpos_m == 0) blen_m = (fq.size() < BL) ? fq.size() : BL;
        chk("burst_len_o", 32'(burst_len_o), 32'(blen_m));
        sb.push_back({rd_data, 1'(bpos_m + 1 == blen_m)});
        bpos_m = (bpos_m + 1 == blen_m) ? 0 : bpos_m + 1;
      end
      occ_m        = occ_m + (rd_en ? 1 : 0) - (hs ? 1 : 0);
      prev_last_hs = hs && m_tlast;
      prev_stall   = m_tvalid && !m_tready;
      prev_data    = m_tdata;
      prev_last    = m_tlast;
      pend_pop     = rd_en;
    end
  end

  initial begin
    int n;
    repeat (3) step();
    rd_rst_n = 1'b1;
    step();

    // Two full bursts with the stream always ready.
    clear_got();
    preload(32'h1, 8);
    enable = 1'b1;
    wait_idle();
    chk("t1_beats", 32'(got_data.size()), 32'd8);
    chk("t1_last4_data", got_data[3], 32'h4);
    chk("t1_last4_flag", 32'(got_last[3]), 32'd1);
    chk("t1_last8_data", got_data[7], 32'h8);
    chk("t1_lasts", 32'(n_lasts()), 32'd2);
    chk("t1_burst_done_cnt", 32'(bd_cnt), 32'd2);
    chk("t1_burst_len", 32'(burst_len_o), 32'd4);

    // Same data with m_tready toggling every cycle.
    clear_got();
    ready_mode = 1;
    preload(32'h11, 8);
    wait_idle();
    chk("t2_beats", 32'(got_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_data.size(); i++)
      chk("t2_order", got_data[i], 32'h11 + 32'(i));
    chk("t2_lasts", 32'(n_lasts()), 32'd2);
    ready_mode = 0;

    // Residual of 3 waits for flush_req.
    clear_got();
    preload(32'h21, 3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_no_pop", 32'(rd_en), 32'd0);
      chk("t3_not_busy", 32'(busy), 32'd0);
    end
    flush_req = 1'b1;
    wait_idle();
    flush_req = 1'b0;
    chk("t3_beats", 32'(got_data.size()), 32'd3);
    chk("t3_last_data", got_data[2], 32'h23);
    chk("t3_lasts", 32'(n_lasts()), 32'd1);
    chk("t3_burst_len", 32'(burst_len_o), 32'd3);

    // FIFO runs dry for two cycles after beat 2.
    clear_got();
    preload(32'h31, 4);
    wait_bpos(2);
    force_empty = 1'b1;
    drive_fifo();
    #1 chk("t4_gap_pop0", 32'(rd_en), 32'd0);
    step();
    chk("t4_gap_pop1", 32'(rd_en), 32'd0);
    force_empty = 1'b0;
    drive_fifo();
    wait_idle();
    chk("t4_beats", 32'(got_data.size()), 32'd4);
    chk("t4_last_data", got_data[3], 32'h34);
    chk("t4_lasts", 32'(n_lasts()), 32'd1);

    // enable drops mid-burst: current burst finishes, nothing new starts.
    clear_got();
    preload(32'h41, 8);
    wait_bpos(1);
    enable = 1'b0;
    wait_idle();
    chk("t5_beats", 32'(got_data.size()), 32'd4);
    chk("t5_left", 32'(fq.size()), 32'd4);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_no_pop", 32'(rd_en), 32'd0);
    end
    enable = 1'b1;
    wait_idle();
    chk("t5_beats_after", 32'(got_data.size()), 32'd8);
    chk("t5_last_data", got_data[7], 32'h48);

    // Reset after beat 2 is popped.
    clear_got();
    preload(32'h51, 8);
    wait_bpos(2);
    rd_rst_n = 1'b0;
    #1;
    chk("t6_rd_en", 32'(rd_en), 32'd0);
    chk("t6_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_tdata", m_tdata, 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_burst_len", 32'(burst_len_o), 32'd0);
    clear_got();
    step();
    step();
    rd_rst_n = 1'b1;
    wait_idle();
    chk("t6_beats", 32'(got_data.size()), 32'd4);
    chk("t6_first", got_data[0], 32'h53);
    chk("t6_last_data", got_data[3], 32'h56);
    chk("t6_lasts", 32'(n_lasts()), 32'd1);
    chk("t6_left", 32'(fq.size()), 32'd2);
    flush_req = 1'b1;
    wait_idle();
    flush_req = 1'b0;
    chk("t6_flush_left", 32'(fq.size()), 32'd0);

    // Random lengths, data, backpressure and FIFO gaps with flush enabled.
    flush_req = 1'b1;
    for (int it = 0; it < 10; it++) begin
      clear_got();
      exp_words.delete();
      n = $urandom_range(1, 15);
      for (int i = 0; i < n; i++) begin
        exp_words.push_back($urandom);
        fq.push_back(exp_words[i]);
      end
      ready_mode = $urandom_range(0, 2);
      rand_empty = 1'b1;
      drive_fifo();
      wait_idle();
      rand_empty  = 1'b0;
      force_empty = 1'b0;
      drive_fifo();
      chk("rnd_beats", 32'(got_data.size()), 32'(n));
      chk("rnd_lasts", 32'(n_lasts()), 32'((n + BL - 1) / BL));
      for (int i = 0; i < n && i < got_data.size(); i++)
        chk("rnd_data", got_data[i], exp_words[i]);
    end
    flush_req  = 1'b0;
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, limit 2000000 reached");
    $fatal(1);
  end

endmodule
